maxpool_nbit_kwin_mch: RTL and testbench
========================================

MAXPOOL_NBIT_KWIN_MCH -- requirements
Module: maxpool_nbit_kwin_mch

Interface
REQ-001 SHALL have parameter N, default 8: element bit-width per channel.
REQ-002 SHALL have parameter K, default 8: pooling window length in samples, K >= 1.
REQ-003 SHALL have parameter C, default 4: number of parallel channels.
REQ-004 SHALL have parameter SIGNED, default 0: 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 SHALL have parameter IW = max(1, clog2(K)): index width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port s_input, input, C*N bits: one sample per channel; channel c occupies bits [c*N +: N].
REQ-009 SHALL have port in_valid, input, 1 bit: s_input carries a sample this cycle.
REQ-010 SHALL have port min_sel, input, 1 bit: 0 = max pool, 1 = min pool.
REQ-011 SHALL have port clear, input, 1 bit: discard the partial window.
REQ-012 SHALL have port o, output, C*N bits: running or final pooled value per channel.
REQ-013 SHALL have port o_idx, output, C*IW bits: window position (0..K-1) of the value held in o, per channel.
REQ-014 SHALL have port o_valid, output, 1 bit: one-cycle pulse when o/o_idx hold a completed window.

Function
REQ-015 SHALL keep a sample counter cnt (0..K-1); only cycles with in_valid=1 count, and idle cycles SHALL leave all state unchanged.
REQ-016 On the first sample of a window (cnt=0), SHALL load o = s_input, set every o_idx lane to 0, and latch min_sel as the window mode.
REQ-017 On a later sample (cnt=j>0), per channel, SHALL replace o and set o_idx = j only if the sample is strictly greater (max mode) or strictly less (min mode) than o.
REQ-018 Ties SHALL retain the earlier value and index.
REQ-019 A change of min_sel mid-window SHALL have no effect until the next window starts.
REQ-020 Compares SHALL be signed when SIGNED=1 and unsigned otherwise; o SHALL carry no width growth.
REQ-021 Latency: o/o_idx SHALL reflect a sample one cycle after the edge that accepts it (registered outputs).
REQ-022 When the K-th sample is accepted (cnt=K-1), SHALL reset cnt to 0 and assert o_valid on the following cycle for exactly one cycle.
REQ-023 Completed window values SHALL remain on o/o_idx until the next accepted sample, which overwrites them per REQ-016.
REQ-024 Window boundaries are back-to-back: a sample on the cycle o_valid is high SHALL start the next window with no bubble.
REQ-025 If K=1, every accepted sample SHALL produce o_valid with o_idx=0.
REQ-026 clear=1 SHALL force cnt=0, force o_valid=0 next cycle, and discard any in_valid sample that cycle; o/o_idx keep their previous values.
REQ-027 Priority SHALL be rst > clear > in_valid.
REQ-028 All C channels SHALL share cnt, mode, and o_valid; the per-channel datapaths are otherwise independent.

Reset
REQ-029 With rst=1 at a rising edge, SHALL set o=0, o_idx=0, o_valid=0, cnt=0, and latched mode = max.
REQ-030 Reset mid-window SHALL abandon the partial window with no o_valid pulse; the first sample after reset SHALL start a new window.

Verification
REQ-031 N=8,K=8,C=1, unsigned max, in_valid continuous, samples 29,34,39,23,99,78,0,87 -> o running 29,34,39,39,99,99,99,99; o_valid one cycle after the 8th sample; o=99, o_idx=4.
REQ-032 Same samples, min_sel=1 -> final o=0, o_idx=6; min_sel toggled to 0 after the 3rd sample -> result unchanged.
REQ-033 SIGNED=1, samples 0x05,0x80,0xFF,0x7F,0x00,0x80,0x10,0x7F -> max: o=0x7F, o_idx=3 (tie at 7 keeps 3); min: o=0x80, o_idx=1.
REQ-034 C=4 with distinct per-lane sequences and random in_valid gaps -> each lane matches an independent model; o_valid exactly once per 8 accepted samples; two back-to-back windows pool independently.
REQ-035 clear after 5 samples, then 8 new samples (all 10 except one 50 at position 2) -> no o_valid from the partial window; final o=50, o_idx=2.
REQ-036 rst asserted after 4 samples -> o=0, o_idx=0, o_valid=0 next cycle; the next 8 samples complete a correct window.

Source files
------------

// File: rtl/maxpool_nbit_kwin_mch.sv
// ============================================================================
// Module      : maxpool_nbit_kwin_mch
// Description : Multi-channel streaming max/min pooling over fixed windows of
//               K accepted samples. Each channel tracks its running extreme
//               value and the window position where that value was first
//               seen. A one-cycle o_valid pulse marks a completed window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_nbit_kwin_mch #(
    parameter int N      = 8,
    parameter int K      = 8,
    parameter int C      = 4,
    parameter int SIGNED = 0,
    parameter int IW     = (K > 1) ? $clog2(K) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [C*N-1:0]  s_input,
    input  logic            in_valid,
    input  logic            min_sel,
    input  logic            clear,
    output logic [C*N-1:0]  o,
    output logic [C*IW-1:0] o_idx,
    output logic            o_valid
);

    // Counter value of the last sample in a window.
    localparam logic [IW-1:0] CNT_LAST = IW'(K - 1);

    // Shared window state.
    logic [IW-1:0]   cnt_q,   cnt_d;
    logic            mode_q,  mode_d;   // 0 = max, 1 = min; latched at window start
    logic            valid_q, valid_d;

    // Per-channel result registers.
    logic [C*N-1:0]  o_q,     o_d;
    logic [C*IW-1:0] idx_q,   idx_d;

    // Per-channel "new sample beats the held value" flag, in the latched mode.
    logic [C-1:0]    w_take;

    // Per-channel strict comparators; ties never replace, so the earliest index wins.
    for (genvar c = 0; c < C; c++) begin : g_ch
        logic [N-1:0] w_cur;
        logic [N-1:0] w_smp;
        logic         w_gt;
        logic         w_lt;

        assign w_cur = o_q[c*N +: N];
        assign w_smp = s_input[c*N +: N];

        if (SIGNED != 0) begin : g_signed
            assign w_gt = $signed(w_smp) > $signed(w_cur);
            assign w_lt = $signed(w_smp) < $signed(w_cur);
        end else begin : g_unsigned
            assign w_gt = w_smp > w_cur;
            assign w_lt = w_smp < w_cur;
        end

        assign w_take[c] = mode_q ? w_lt : w_gt;
    end

    // Next-state: clear beats a sample; a sample at cnt=0 opens a fresh window.
    always_comb begin
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        o_d     = o_q;
        idx_d   = idx_q;
        valid_d = 1'b0;

        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            if (cnt_q == '0) begin
                o_d    = s_input;
                idx_d  = '0;
                mode_d = min_sel;
            end else begin
                for (int c = 0; c < C; c++) begin
                    if (w_take[c]) begin
                        o_d[c*N +: N]    = s_input[c*N +: N];
                        idx_d[c*IW +: IW] = cnt_q;
                    end
                end
            end

            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset back to an empty max-mode window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            o_q     <= '0;
            idx_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
        end
    end

    assign o       = o_q;
    assign o_idx   = idx_q;
    assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_nbit_kwin_mch.sv
// ============================================================================
// Module      : tb_maxpool_nbit_kwin_mch
// Description : Self-checking bench for maxpool_nbit_kwin_mch: an unsigned
//               4-channel instance, a signed 1-channel instance and a K=1
//               instance, with a queue of expected completed windows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_nbit_kwin_mch;

    localparam int N = 8;
    localparam int K = 8;
    localparam int C = 4;

    typedef struct {
        logic [C*N-1:0] o;
        logic [C*3-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // Unsigned, 4 channels
    logic [C*N-1:0] s_u   = '0;
    logic           v_u   = 1'b0;
    logic           ms_u  = 1'b0;
    logic           clr_u = 1'b0;
    logic [C*N-1:0] o_u;
    logic [C*3-1:0] idx_u;
    logic           ov_u;

    // Signed, 1 channel
    logic [7:0] s_s   = '0;
    logic       v_s   = 1'b0;
    logic       ms_s  = 1'b0;
    logic       clr_s = 1'b0;
    logic [7:0] o_s;
    logic [2:0] idx_s;
    logic       ov_s;

    // K = 1, 2 channels
    logic [15:0] s_k   = '0;
    logic        v_k   = 1'b0;
    logic        ms_k  = 1'b0;
    logic        clr_k = 1'b0;
    logic [15:0] o_k;
    logic [1:0]  idx_k;
    logic        ov_k;

    maxpool_nbit_kwin_mch #(.N(8), .K(8), .C(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .s_input(s_u), .in_valid(v_u), .min_sel(ms_u),
        .clear(clr_u), .o(o_u), .o_idx(idx_u), .o_valid(ov_u)
    );

    maxpool_nbit_kwin_mch #(.N(8), .K(8), .C(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .s_input(s_s), .in_valid(v_s), .min_sel(ms_s),
        .clear(clr_s), .o(o_s), .o_idx(idx_s), .o_valid(ov_s)
    );

    maxpool_nbit_kwin_mch #(.N(8), .K(1), .C(2), .SIGNED(0)) dut_k (
        .clk(clk), .rst(rst), .s_input(s_k), .in_valid(v_k), .min_sel(ms_k),
        .clear(clr_k), .o(o_k), .o_idx(idx_k), .o_valid(ov_k)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the unsigned instance
    logic [7:0] m_o   [C];
    logic [2:0] m_idx [C];
    int         m_cnt   = 0;
    logic       m_mode  = 1'b0;
    logic       m_valid = 1'b0;
    exp_t       q_u[$];

    function automatic logic [C*N-1:0] pack_o();
        logic [C*N-1:0] r;
        for (int c = 0; c < C; c++) r[c*8 +: 8] = m_o[c];
        return r;
    endfunction

    function automatic logic [C*3-1:0] pack_idx();
        logic [C*3-1:0] r;
        for (int c = 0; c < C; c++) r[c*3 +: 3] = m_idx[c];
        return r;
    endfunction

    // One clock of stimulus on the unsigned instance, then model update.
    task automatic step_u(input logic v, input logic [31:0] d, input logic ms,
                          input logic clr, input logic rs);
        logic [7:0] smp;
        exp_t e;
        @(negedge clk);
        rst = rs; v_u = v; s_u = d; ms_u = ms; clr_u = clr;
        @(posedge clk);
        #1;
        if (rs) begin
            for (int c = 0; c < C; c++) begin m_o[c] = '0; m_idx[c] = '0; end
            m_cnt = 0; m_mode = 1'b0; m_valid = 1'b0;
        end else if (clr) begin
            m_cnt = 0; m_valid = 1'b0;
        end else if (v) begin
            if (m_cnt == 0) begin
                m_mode = ms;
                for (int c = 0; c < C; c++) begin m_o[c] = d[c*8 +: 8]; m_idx[c] = '0; end
            end else begin
                for (int c = 0; c < C; c++) begin
                    smp = d[c*8 +: 8];
                    if (m_mode ? (smp < m_o[c]) : (smp > m_o[c])) begin
                        m_o[c] = smp; m_idx[c] = 3'(m_cnt);
                    end
                end
            end
            if (m_cnt == K - 1) begin
                m_cnt = 0; m_valid = 1'b1;
                e.o = pack_o(); e.idx = pack_idx();
                q_u.push_back(e);
            end else begin
                m_cnt++; m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
        rst = 1'b0; v_u = 1'b0; clr_u = 1'b0;
    endtask

    task automatic step_s(input logic v, input logic [7:0] d, input logic ms);
        @(negedge clk);
        v_s = v; s_s = d; ms_s = ms;
        @(posedge clk);
        #1;
        v_s = 1'b0;
    endtask

    task automatic step_k(input logic v, input logic [15:0] d, input logic clr);
        @(negedge clk);
        v_k = v; s_k = d; clr_k = clr;
        @(posedge clk);
        #1;
        v_k = 1'b0; clr_k = 1'b0;
    endtask

    task automatic test_reset();
        step_u(0, 0, 0, 0, 1);
        step_u(0, 0, 0, 0, 1);
        n_cmp++; if (o_u !== '0)   begin n_err++; $display("FAIL reset_o_u: got %h expected 0", o_u); end
        n_cmp++; if (idx_u !== '0) begin n_err++; $display("FAIL reset_idx_u: got %h expected 0", idx_u); end
        n_cmp++; if (ov_u !== 1'b0) begin n_err++; $display("FAIL reset_valid_u: got %b expected 0", ov_u); end
        n_cmp++; if (o_s !== '0 || idx_s !== '0 || ov_s !== 1'b0)
            begin n_err++; $display("FAIL reset_s: got o=%h idx=%h v=%b expected 0", o_s, idx_s, ov_s); end
        n_cmp++; if (o_k !== '0 || ov_k !== 1'b0)
            begin n_err++; $display("FAIL reset_k: got o=%h v=%b expected 0", o_k, ov_k); end
    endtask

    task automatic test_max_basic();
        int seq[8]     = '{29, 34, 39, 23, 99, 78, 0, 87};
        int exp_run[8] = '{29, 34, 39, 39, 99, 99, 99, 99};
        logic [31:0] d;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            d[7:0]   = 8'(seq[i]);
            d[15:8]  = 8'(255 - seq[i]);
            d[23:16] = 8'(seq[7-i]);
            d[31:24] = 8'(seq[i]) ^ 8'h55;
            step_u(1, d, 0, 0, 0);
            n_cmp++; if (o_u[7:0] !== 8'(exp_run[i]))
                begin n_err++; $display("FAIL max_running[%0d]: got %0d expected %0d", i, o_u[7:0], exp_run[i]); end
            n_cmp++; if (ov_u !== (i == 7))
                begin n_err++; $display("FAIL max_valid[%0d]: got %b expected %b", i, ov_u, (i == 7)); end
        end
        n_cmp++; if (o_u[7:0] !== 8'd99 || idx_u[2:0] !== 3'd4)
            begin n_err++; $display("FAIL max_final_lane0: got o=%0d idx=%0d expected o=99 idx=4", o_u[7:0], idx_u[2:0]); end
        n_cmp++;
        if (q_u.size() != 1) begin
            n_err++; $display("FAIL max_queue: got %0d entries expected 1", q_u.size());
        end else begin
            e = q_u.pop_front();
            if (o_u !== e.o || idx_u !== e.idx)
                begin n_err++; $display("FAIL max_window: got o=%h idx=%h expected o=%h idx=%h", o_u, idx_u, e.o, e.idx); end
        end
        // Completed window holds while idle and the pulse does not repeat.
        step_u(0, 32'hFFFF_FFFF, 0, 0, 0);
        step_u(0, 32'hFFFF_FFFF, 0, 0, 0);
        n_cmp++; if (ov_u !== 1'b0 || o_u !== pack_o() || idx_u !== pack_idx())
            begin n_err++; $display("FAIL max_hold: got o=%h idx=%h v=%b expected o=%h idx=%h v=0", o_u, idx_u, ov_u, pack_o(), pack_idx()); end
    endtask

    task automatic test_min_mode();
        int seq[8] = '{29, 34, 39, 23, 99, 78, 0, 87};
        exp_t e;
        for (int i = 0; i < 8; i++)
            step_u(1, {4{8'(seq[i])}}, (i < 3) ? 1'b1 : 1'b0, 0, 0);
        n_cmp++; if (ov_u !== 1'b1) begin n_err++; $display("FAIL min_valid: got %b expected 1", ov_u); end
        n_cmp++; if (o_u[7:0] !== 8'd0 || idx_u[2:0] !== 3'd6)
            begin n_err++; $display("FAIL min_final_lane0: got o=%0d idx=%0d expected o=0 idx=6", o_u[7:0], idx_u[2:0]); end
        n_cmp++;
        if (q_u.size() != 1) begin
            n_err++; $display("FAIL min_queue: got %0d entries expected 1", q_u.size());
        end else begin
            e = q_u.pop_front();
            if (o_u !== e.o || idx_u !== e.idx)
                begin n_err++; $display("FAIL min_window: got o=%h idx=%h expected o=%h idx=%h", o_u, idx_u, e.o, e.idx); end
        end
    endtask

    task automatic test_signed();
        logic [7:0] seq[8] = '{8'h05, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h10, 8'h7F};
        for (int i = 0; i < 8; i++) step_s(1, seq[i], 0);
        n_cmp++; if (ov_s !== 1'b1 || o_s !== 8'h7F || idx_s !== 3'd3)
            begin n_err++; $display("FAIL signed_max: got o=%h idx=%0d v=%b expected o=7f idx=3 v=1", o_s, idx_s, ov_s); end
        for (int i = 0; i < 8; i++) step_s(1, seq[i], 1);
        n_cmp++; if (ov_s !== 1'b1 || o_s !== 8'h80 || idx_s !== 3'd1)
            begin n_err++; $display("FAIL signed_min: got o=%h idx=%0d v=%b expected o=80 idx=1 v=1", o_s, idx_s, ov_s); end
    endtask

    task automatic test_back_to_back();
        int accepted;
        int n_valid = 0;
        int guard;
        exp_t e;
        logic ms;
        for (int w = 0; w < 2; w++) begin
            accepted = 0;
            guard = 0;
            ms = 1'($urandom_range(0, 1));
            while (accepted < 8 && guard < 100) begin
                guard++;
                if (accepted > 0 && $urandom_range(0, 2) == 0) begin
                    step_u(0, $urandom, ~ms, 0, 0);
                end else begin
                    step_u(1, $urandom, (accepted == 0) ? ms : 1'($urandom_range(0, 1)), 0, 0);
                    accepted++;
                end
                n_cmp++; if (o_u !== pack_o() || idx_u !== pack_idx())
                    begin n_err++; $display("FAIL b2b_running w%0d: got o=%h idx=%h expected o=%h idx=%h", w, o_u, idx_u, pack_o(), pack_idx()); end
                if (ov_u) begin
                    n_valid++;
                    n_cmp++;
                    if (q_u.size() == 0) begin
                        n_err++; $display("FAIL b2b_unexpected_valid w%0d: got valid with empty queue expected none", w);
                    end else begin
                        e = q_u.pop_front();
                        if (o_u !== e.o || idx_u !== e.idx)
                            begin n_err++; $display("FAIL b2b_window w%0d: got o=%h idx=%h expected o=%h idx=%h", w, o_u, idx_u, e.o, e.idx); end
                    end
                end
            end
        end
        n_cmp++; if (n_valid != 2) begin n_err++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid); end
    endtask

    task automatic test_clear();
        logic [31:0] held_o;
        logic [11:0] held_idx;
        int n_valid = 0;
        exp_t e;
        for (int i = 0; i < 5; i++) step_u(1, 32'hC8C8_C8C8 + 32'(i), 0, 0, 0);
        held_o = o_u; held_idx = idx_u;
        step_u(1, 32'hFFFF_FFFF, 0, 1, 0);
        n_cmp++; if (ov_u !== 1'b0 || o_u !== held_o || idx_u !== held_idx)
            begin n_err++; $display("FAIL clear_hold: got o=%h idx=%h v=%b expected o=%h idx=%h v=0", o_u, idx_u, ov_u, held_o, held_idx); end
        for (int i = 0; i < 8; i++) begin
            step_u(1, (i == 2) ? 32'h3232_3232 : 32'h0A0A_0A0A, 0, 0, 0);
            if (ov_u) n_valid++;
        end
        n_cmp++; if (n_valid != 1 || ov_u !== 1'b1)
            begin n_err++; $display("FAIL clear_valid_count: got %0d last=%b expected 1 last=1", n_valid, ov_u); end
        n_cmp++; if (o_u !== 32'h3232_3232 || idx_u !== {4{3'd2}})
            begin n_err++; $display("FAIL clear_window: got o=%h idx=%h expected o=32323232 idx=%h", o_u, idx_u, {4{3'd2}}); end
        n_cmp++;
        if (q_u.size() != 1) begin
            n_err++; $display("FAIL clear_queue: got %0d entries expected 1", q_u.size());
        end else begin
            e = q_u.pop_front();
            if (o_u !== e.o || idx_u !== e.idx)
                begin n_err++; $display("FAIL clear_model: got o=%h idx=%h expected o=%h idx=%h", o_u, idx_u, e.o, e.idx); end
        end
    endtask

    task automatic test_reset_mid();
        int n_valid = 0;
        exp_t e;
        for (int i = 0; i < 4; i++) step_u(1, 32'h9080_7060 + 32'(i), 1, 0, 0);
        step_u(1, 32'h1111_1111, 0, 0, 1);
        n_cmp++; if (o_u !== '0 || idx_u !== '0 || ov_u !== 1'b0)
            begin n_err++; $display("FAIL rstmid_state: got o=%h idx=%h v=%b expected 0", o_u, idx_u, ov_u); end
        for (int i = 0; i < 8; i++) begin
            step_u(1, $urandom, 0, 0, 0);
            if (ov_u) n_valid++;
        end
        n_cmp++; if (n_valid != 1 || ov_u !== 1'b1)
            begin n_err++; $display("FAIL rstmid_valid_count: got %0d last=%b expected 1 last=1", n_valid, ov_u); end
        n_cmp++;
        if (q_u.size() != 1) begin
            n_err++; $display("FAIL rstmid_queue: got %0d entries expected 1", q_u.size());
        end else begin
            e = q_u.pop_front();
            if (o_u !== e.o || idx_u !== e.idx)
                begin n_err++; $display("FAIL rstmid_window: got o=%h idx=%h expected o=%h idx=%h", o_u, idx_u, e.o, e.idx); end
        end
    endtask

    task automatic test_k1();
        logic [15:0] d[3] = '{16'hA53C, 16'h0001, 16'hFF7E};
        for (int i = 0; i < 3; i++) begin
            step_k(1, d[i], 0);
            n_cmp++; if (ov_k !== 1'b1 || o_k !== d[i] || idx_k !== 2'b00)
                begin n_err++; $display("FAIL k1_sample[%0d]: got o=%h idx=%b v=%b expected o=%h idx=00 v=1", i, o_k, idx_k, ov_k, d[i]); end
        end
        step_k(0, 16'h1234, 0);
        n_cmp++; if (ov_k !== 1'b0 || o_k !== 16'hFF7E)
            begin n_err++; $display("FAIL k1_idle: got o=%h v=%b expected o=ff7e v=0", o_k, ov_k); end
        step_k(1, 16'h1234, 1);
        n_cmp++; if (ov_k !== 1'b0 || o_k !== 16'hFF7E)
            begin n_err++; $display("FAIL k1_clear: got o=%h v=%b expected o=ff7e v=0", o_k, ov_k); end
    endtask

    initial begin
        for (int c = 0; c < C; c++) begin m_o[c] = '0; m_idx[c] = '0; end
        test_reset();
        test_max_basic();
        test_min_mode();
        test_signed();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_k1();
        n_cmp++; if (q_u.size() != 0)
            begin n_err++; $display("FAIL leftover_queue: got %0d entries expected 0", q_u.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
